// File: rtl/tl_ul_scratchpad.sv
// TileLink-UL scratchpad slave: flop-based 64-bit word store behind a one-entry D register.
// Optional macro TL_SCRATCHPAD_DENIED_EN adds auto_in_d_bits_denied for out-of-range/unsupported requests.
module tl_ul_scratchpad #(
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 12,
  parameter int SOURCE_W = 9,
  parameter int DATA_W   = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  auto_in_a_ready,
  input  logic                  auto_in_a_valid,
  input  logic [2:0]            auto_in_a_bits_opcode,
  input  logic [1:0]            auto_in_a_bits_size,
  input  logic [SOURCE_W-1:0]   auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]     auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0]   auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]     auto_in_a_bits_data,
  input  logic                  auto_in_d_ready,
  output logic                  auto_in_d_valid,
  output logic [2:0]            auto_in_d_bits_opcode,
  output logic [1:0]            auto_in_d_bits_size,
  output logic [SOURCE_W-1:0]   auto_in_d_bits_source,
`ifdef TL_SCRATCHPAD_DENIED_EN
  output logic                  auto_in_d_bits_denied,
`endif
  output logic [DATA_W-1:0]     auto_in_d_bits_data
);

  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 3;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] D_ACK          = 3'd0;
  localparam logic [2:0] D_ACK_DATA     = 3'd1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              vld_p0;
  logic [2:0]        opcode_p0;
  logic [1:0]        size_p0;
  logic [SOURCE_W-1:0] source_p0;
  logic [DATA_W-1:0] data_p0;

  logic              a_fire;
  logic              is_get;
  logic              is_put;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] mem_idx;
  logic [DATA_W-1:0] rd_word;
  logic              unused_addr_lsb;

  // Lane selection comes from the mask, so the sub-word address bits carry no information.
  assign unused_addr_lsb = ^auto_in_a_bits_address[2:0];

  function automatic logic [2:0] resp_opcode(input logic get);
    return get ? D_ACK_DATA : D_ACK;
  endfunction

  function automatic logic [DATA_W-1:0] resp_data(input logic get, input logic hit,
                                                  input logic [DATA_W-1:0] word);
    return (get && hit) ? word : '0;
  endfunction

  assign auto_in_a_ready = !vld_p0 | auto_in_d_ready;
  assign a_fire          = auto_in_a_valid & auto_in_a_ready;

  assign is_get   = (auto_in_a_bits_opcode == OP_GET);
  assign is_put   = (auto_in_a_bits_opcode == OP_PUT_FULL) ||
                    (auto_in_a_bits_opcode == OP_PUT_PARTIAL);
  assign idx      = auto_in_a_bits_address[ADDR_W-1:3];
  assign in_range = (32'(idx) < DEPTH);
  assign mem_idx  = idx[MEM_AW-1:0];
  assign rd_word  = in_range ? mem[mem_idx] : '0;

  // Storage: byte-lane writes at the fire edge, no reset.
  always_ff @(posedge clock) begin
    if (a_fire && is_put && in_range) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (auto_in_a_bits_mask[i]) begin
          mem[mem_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
        end
      end
    end
  end

  // Stage p0: one-entry D register, loads on fire, clears when drained without a new fire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p0    <= 1'b0;
      opcode_p0 <= '0;
      size_p0   <= '0;
      source_p0 <= '0;
      data_p0   <= '0;
    end else if (a_fire) begin
      vld_p0    <= 1'b1;
      opcode_p0 <= resp_opcode(is_get);
      size_p0   <= auto_in_a_bits_size;
      source_p0 <= auto_in_a_bits_source;
      data_p0   <= resp_data(is_get, in_range, rd_word);
    end else if (auto_in_d_ready) begin
      vld_p0    <= 1'b0;
    end
  end

`ifdef TL_SCRATCHPAD_DENIED_EN
  logic denied_p0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      denied_p0 <= 1'b0;
    end else if (a_fire) begin
      denied_p0 <= !in_range || !(is_get || is_put);
    end
  end

  assign auto_in_d_bits_denied = denied_p0;
`endif

  assign auto_in_d_valid       = vld_p0;
  assign auto_in_d_bits_opcode = opcode_p0;
  assign auto_in_d_bits_size   = size_p0;
  assign auto_in_d_bits_source = source_p0;
  assign auto_in_d_bits_data   = data_p0;

endmodule

// File: tb/tb_tl_ul_scratchpad.sv
// Bench for tl_ul_scratchpad: queue-based response model, per-cycle compare, directed literal checks.
`timescale 1ns/1ps
module tb_tl_ul_scratchpad;
  localparam int DEPTH    = 64;
  localparam int ADDR_W   = 12;
  localparam int SOURCE_W = 9;
  localparam int DATA_W   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_ready;
  logic        a_valid = 1'b0;
  logic [2:0]  a_op = '0;
  logic [1:0]  a_size = '0;
  logic [8:0]  a_src = '0;
  logic [11:0] a_addr = '0;
  logic [7:0]  a_mask = '0;
  logic [63:0] a_data = '0;
  logic        d_ready = 1'b1;
  logic        d_valid;
  logic [2:0]  d_op;
  logic [1:0]  d_size;
  logic [8:0]  d_src;
  logic [63:0] d_data;
  logic        d_denied;

  always #10 clk = ~clk;

  tl_ul_scratchpad #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W), .DATA_W(DATA_W)) dut (
    .clock                  (clk),
    .reset                  (rst_n),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_bits_opcode  (a_op),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_src),
    .auto_in_a_bits_address (a_addr),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_bits_opcode  (d_op),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_src),
`ifdef TL_SCRATCHPAD_DENIED_EN
    .auto_in_d_bits_denied  (d_denied),
`endif
    .auto_in_d_bits_data    (d_data)
  );

`ifndef TL_SCRATCHPAD_DENIED_EN
  assign d_denied = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [8:0]  src;
    logic [63:0] data;
    logic        denied;
    int          cyc;
  } beat_t;

  beat_t       q[$];
  beat_t       got[$];
  logic [63:0] m_mem [DEPTH];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] fill_pat(input int i);
    return {32'hDEAD0000 + 32'(i), 32'hBEEF0000 + 32'(i)};
  endfunction

  function automatic beat_t got_at(input int k);
    beat_t b;
    b = '{op: 3'd7, size: 2'd0, src: 9'h0, data: 64'h0, denied: 1'b0, cyc: -100};
    if (k < got.size()) b = got[k];
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: each accepted request becomes one queued beat; the queue head is what D shows.
  int    m_idx;
  bit    m_inr;
  bit    m_rdy;
  beat_t m_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_rdy = (q.size() == 0) || d_ready;
      if (q.size() != 0 && d_ready) void'(q.pop_front());
      if (a_valid && m_rdy) begin
        m_idx = int'(a_addr) / 8;
        m_inr = m_idx < DEPTH;
        m_b.op = 3'd0;
        m_b.size = a_size;
        m_b.src = a_src;
        m_b.data = 64'h0;
        m_b.denied = !m_inr;
        m_b.cyc = 0;
        case (a_op)
          3'd4: begin
            m_b.op = 3'd1;
            if (m_inr) m_b.data = m_mem[m_idx];
          end
          3'd0, 3'd1: begin
            if (m_inr)
              for (int b = 0; b < 8; b++)
                if (a_mask[b]) m_mem[m_idx][8*b +: 8] = a_data[8*b +: 8];
          end
          default: m_b.denied = 1'b1;
        endcase
        q.push_back(m_b);
      end
    end
  end

  beat_t g;
  always @(negedge clk) begin
    chk("a_ready", a_ready, (q.size() == 0) || d_ready);
    chk("d_valid", d_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("d_opcode", d_op, q[0].op);
      chk("d_size", d_size, q[0].size);
      chk("d_source", d_src, q[0].src);
      chk("d_data", d_data, q[0].data);
`ifdef TL_SCRATCHPAD_DENIED_EN
      chk("d_denied", d_denied, q[0].denied);
`endif
    end
    if (d_valid && d_ready) begin
      g.op = d_op; g.size = d_size; g.src = d_src; g.data = d_data;
      g.denied = d_denied; g.cyc = cyc;
      got.push_back(g);
    end
  end

  task automatic send(input logic [2:0] op, input logic [11:0] addr, input logic [7:0] mask,
                      input logic [63:0] data, input logic [8:0] src, input logic [1:0] size);
    bit fired = 1'b0;
    a_valid = 1'b1; a_op = op; a_addr = addr; a_mask = mask;
    a_data = data; a_src = src; a_size = size;
    for (int n = 0; n < 50 && !fired; n++) begin
      @(negedge clk);
      if (a_ready) fired = 1'b1;
    end
    chk("send_fire", fired, 1'b1);
    @(posedge clk); #2;
    a_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic chk_beat(input string name, input int k, input logic [2:0] op,
                          input logic [8:0] src, input logic [63:0] data);
    beat_t b;
    b = got_at(k);
    chk({name, "_op"}, b.op, op);
    chk({name, "_src"}, b.src, src);
    chk({name, "_data"}, b.data, data);
  endtask

  initial begin
    #1;
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_d_opcode", d_op, 3'd0);
    chk("rst_d_size", d_size, 2'd0);
    chk("rst_d_source", d_src, 9'd0);
    chk("rst_d_data", d_data, 64'd0);
    chk("rst_d_denied", d_denied, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) send(3'd0, 12'(i * 8), 8'hFF, fill_pat(i), 9'(i), 2'd3);
    drain();

    // PutFull then Get to the same word, back to back.
    got.delete();
    send(3'd0, 12'h010, 8'hFF, 64'h1122334455667788, 9'h1A5, 2'd3);
    send(3'd4, 12'h010, 8'hFF, 64'h0, 9'h0B2, 2'd3);
    drain();
    chk("t1_count", got.size(), 2);
    chk_beat("t1_put", 0, 3'd0, 9'h1A5, 64'h0);
    chk_beat("t1_get", 1, 3'd1, 9'h0B2, 64'h1122334455667788);
    chk("t1_b2b", got_at(1).cyc - got_at(0).cyc, 1);

    // PutPartial low lanes.
    got.delete();
    send(3'd1, 12'h010, 8'h0F, 64'hFFFFFFFF_AABBCCDD, 9'h011, 2'd2);
    send(3'd4, 12'h010, 8'hFF, 64'h0, 9'h012, 2'd3);
    drain();
    chk_beat("t2_get", 1, 3'd1, 9'h012, 64'h11223344AABBCCDD);

    // Backpressure: D held for 3 cycles, pending Get fires on release.
    got.delete();
    d_ready = 1'b0;
    send(3'd4, 12'h018, 8'hFF, 64'h0, 9'h005, 2'd3);
    fork
      send(3'd4, 12'h000, 8'hFF, 64'h0, 9'h006, 2'd3);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_a_ready", a_ready, 1'b0);
          chk("stall_d_data", d_data, 64'hDEAD0003_BEEF0003);
        end
        @(posedge clk); #2;
        d_ready = 1'b1;
      end
    join
    drain();
    chk_beat("t3_first", 0, 3'd1, 9'h005, 64'hDEAD0003_BEEF0003);
    chk_beat("t3_second", 1, 3'd1, 9'h006, 64'hDEAD0000_BEEF0000);
    chk("t3_b2b", got_at(1).cyc - got_at(0).cyc, 1);

    // Streaming 8 Gets at full throughput.
    got.delete();
    for (int i = 8; i < 16; i++) send(3'd4, 12'(i * 8), 8'hFF, 64'h0, 9'(9'h100 + i), 2'd3);
    drain();
    chk("t4_count", got.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("t4_src", got_at(k).src, 9'(9'h100 + 8 + k));
      chk("t4_data", got_at(k).data, fill_pat(8 + k));
      chk("t4_cyc", got_at(k).cyc - got_at(0).cyc, k);
    end

    // Out of range accesses, then word 0 must be intact.
    got.delete();
    send(3'd4, 12'h200, 8'hFF, 64'h0, 9'h020, 2'd3);
    send(3'd0, 12'h200, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 9'h021, 2'd3);
    send(3'd4, 12'h000, 8'hFF, 64'h0, 9'h022, 2'd3);
    drain();
    chk_beat("t5_oor_get", 0, 3'd1, 9'h020, 64'h0);
    chk_beat("t5_oor_put", 1, 3'd0, 9'h021, 64'h0);
    chk_beat("t5_word0", 2, 3'd1, 9'h022, 64'hDEAD0000_BEEF0000);
`ifdef TL_SCRATCHPAD_DENIED_EN
    chk("t5_denied_get", got_at(0).denied, 1'b1);
    chk("t5_denied_put", got_at(1).denied, 1'b1);
    chk("t5_denied_ok", got_at(2).denied, 1'b0);
`endif

    // Unsupported opcode, then mask=0 Put.
    got.delete();
    send(3'd2, 12'h008, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 9'h030, 2'd0);
    send(3'd4, 12'h008, 8'hFF, 64'h0, 9'h031, 2'd3);
    send(3'd1, 12'h018, 8'h00, 64'hFFFFFFFF_FFFFFFFF, 9'h032, 2'd3);
    send(3'd4, 12'h018, 8'hFF, 64'h0, 9'h033, 2'd3);
    drain();
    chk_beat("t6_unsup", 0, 3'd0, 9'h030, 64'h0);
    chk_beat("t6_word1", 1, 3'd1, 9'h031, 64'hDEAD0001_BEEF0001);
    chk_beat("t6_mask0", 2, 3'd0, 9'h032, 64'h0);
    chk_beat("t6_word3", 3, 3'd1, 9'h033, 64'hDEAD0003_BEEF0003);
`ifdef TL_SCRATCHPAD_DENIED_EN
    chk("t6_denied", got_at(0).denied, 1'b1);
`endif

    // Reset while a beat is held.
    d_ready = 1'b0;
    send(3'd4, 12'h020, 8'hFF, 64'h0, 9'h077, 2'd3);
    #1;
    chk("t7_pre_valid", d_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", d_valid, 1'b0);
    chk("t7_rst_data", d_data, 64'h0);
    chk("t7_rst_src", d_src, 9'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    d_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tl_ul_scratchpad.md
Name: tl_ul_scratchpad

Overview:
- TileLink-UL slave memory that sits directly downstream of the interconnect coupler's fragmenter output.
- Consumes the fragmented A channel (single-beat, size ≤ 3) and returns one D beat per request.
- Provides a small flop-based scratchpad: word-addressed, 64-bit, byte-maskable.
- One-cycle request-to-response latency; the D register stalls correctly under backpressure.

Parameters:
- DEPTH, 64, number of 64-bit words; addressable range is 0 .. DEPTH*8-1 bytes.
- ADDR_W, 12, A-channel address width.
- SOURCE_W, 9, source ID width.
- DATA_W, 64, beat width; mask width is DATA_W/8.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- auto_in_a_ready  out  1  A-channel ready.
- auto_in_a_valid  in  1  A-channel valid.
- auto_in_a_bits_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get; all others unsupported.
- auto_in_a_bits_size  in  2  log2 of bytes; echoed on D.
- auto_in_a_bits_source  in  SOURCE_W  echoed on D.
- auto_in_a_bits_address  in  ADDR_W  byte address.
- auto_in_a_bits_mask  in  DATA_W/8  byte enables.
- auto_in_a_bits_data  in  DATA_W  write data.
- auto_in_d_ready  in  1  D-channel ready.
- auto_in_d_valid  out  1  D-channel valid.
- auto_in_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData.
- auto_in_d_bits_size  out  2  echoed size.
- auto_in_d_bits_source  out  SOURCE_W  echoed source.
- auto_in_d_bits_data  out  DATA_W  read data; 0 for AccessAck.

Behaviour:
- Reset values: d_valid=0; d_opcode, d_size, d_source and d_data are all 0. Storage array is not reset.
- a_ready = !d_valid_q | d_ready. This is combinational, so back-to-back requests sustain full throughput.
- A fire = a_valid & a_ready. A response is registered on the fire edge, so d_valid rises in cycle N+1 for a fire in cycle N.
- D beat fields are held stable while d_valid & !d_ready.
- Fire while D drains in the same cycle: the old beat retires and the new beat loads. d_valid stays 1 with no bubble.
- D retires with no new fire: d_valid goes to 0.
- Word index = address[ADDR_W-1:3]. In range iff index < DEPTH. address[2:0] is ignored; the mask carries lane selection.
- Get: d_opcode=1, d_data = array[index] (full word, all lanes) captured at fire. Out of range: d_data=0.
- PutFull / PutPartial: for each byte i with mask[i]=1, array[index].byte[i] is written at the fire edge. d_opcode=0, d_data=0. Out-of-range writes are dropped.
- Unsupported opcodes (2, 3, 5, 6, 7): d_opcode=0, d_data=0, no array write.
- Read-after-write: a Get fired the cycle after a Put to the same word returns the updated bytes.
- Mask=0 Put: no bytes change; AccessAck is still returned.
- Reset mid-response: d_valid drops to 0 immediately (async). The beat is lost. Array contents are retained but undefined after power-up.
- No internal state machine beyond the one-entry D register (EMPTY/FULL). EMPTY→FULL on fire. FULL→EMPTY on d_ready without fire. FULL→FULL on fire with d_ready, or on stall.

Optional Feature:
- Macro: TL_SCRATCHPAD_DENIED_EN.
- When defined: adds output port auto_in_d_bits_denied (1 bit, reset 0, held with the beat). It is 1 for any out-of-range access or unsupported opcode; d_data stays 0 in those cases.
- When undefined: the port is absent, and errors are silently acked as described in Behaviour.

Test Plan:
- PutFull addr 0x010, mask 0xFF, data 0x1122334455667788, source 0x1A5; next-cycle Get addr 0x010 -> AccessAck (src 0x1A5) at N+1, then AccessAckData data 0x1122334455667788 at N+2.
- PutPartial addr 0x010, mask 0x0F, data 0xFFFFFFFF_AABBCCDD; then Get -> data 0x11223344AABBCCDD.
- Hold d_ready=0 for 3 cycles after a Get -> a_ready=0, D fields stable all 3 cycles. Release -> a_ready=1 same cycle and the pending A fires.
- Stream of 8 Gets with a_valid=1 and d_ready=1 -> 8 D beats on consecutive cycles, sources echoed in order.
- Get addr 0x200 (index 64 ≥ DEPTH) -> AccessAckData data 0. Put addr 0x200 is dropped; array word 0 is unchanged. With TL_SCRATCHPAD_DENIED_EN, denied=1 on both.
- Opcode 2 at addr 0x008 -> AccessAck data 0, word 1 unchanged. Assert reset (0) while d_valid=1 -> d_valid=0 immediately.
